// File: rtl/i2c_reg_sequencer.sv
// Write-only I2C register sequencer: after a power-up delay, sends NUM_WORDS 16-bit table words to one device.
// Optional build macro I2C_SEQ_ACK_CHECK_EN enables ACK sampling, per-word retry and the ack_err flag.
module i2c_reg_sequencer #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned NUM_WORDS  = 8,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int unsigned INIT_DELAY = 160000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        inclk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  word_idx,
    input  logic [15:0] word_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 2);
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned FRM_W  = 27;
    localparam int unsigned CNT_W  = 32;

`ifdef I2C_SEQ_ACK_CHECK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         ph_q, ph_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRM_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [7:0]         word_idx_q, word_idx_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               nack_q, nack_d;
    logic               pending_q, pending_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ack_err_q, ack_err_d;
    logic               scl_q, scl_d;
    logic               sda_q, sda_d;

    logic               tick_c;
    logic               end_c;
    logic               last_word_c;
    logic               ack_bit_c;
    logic [FRM_W-1:0]   frame_c;

    assign tick_c      = (div_q == DIV_W'(CLK_DIV - 1));
    assign end_c       = tick_c && (ph_q == 2'd3);
    assign last_word_c = (word_idx_q == 8'(NUM_WORDS - 1));
    assign ack_bit_c   = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
    // Ones in the ACK slots release SDA so the slave can drive it.
    assign frame_c     = {DEV_ADDR, 1'b0, 1'b1, word_data[15:8], 1'b1, word_data[7:0], 1'b1};

    // State register
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            div_q      <= '0;
            ph_q       <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            init_cnt_q <= '0;
            word_idx_q <= '0;
            retry_q    <= '0;
            nack_q     <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b0;
            sda_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            init_cnt_q <= init_cnt_d;
            word_idx_q <= word_idx_d;
            retry_q    <= retry_d;
            nack_q     <= nack_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        div_d      = div_q + DIV_W'(1);
        ph_d       = ph_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        init_cnt_d = init_cnt_q;
        word_idx_d = word_idx_q;
        retry_d    = retry_q;
        nack_d     = nack_q;
        pending_d  = pending_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        scl_d      = 1'b0;
        sda_d      = 1'b0;

        if (tick_c) begin
            div_d = '0;
            ph_d  = ph_q + 2'd1;
        end
        // A request during a running sequence is remembered; during INIT it is absorbed.
        if (start && (state_q != S_INIT) && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            S_INIT: begin
                div_d  = '0;
                ph_d   = '0;
                busy_d = 1'b1;
                if ((init_cnt_q + CNT_W'(1)) >= CNT_W'(INIT_DELAY)) begin
                    init_cnt_d = '0;
                    state_d    = S_START;
                    word_idx_d = '0;
                    retry_d    = '0;
                    nack_d     = 1'b0;
                    ack_err_d  = 1'b0;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                div_d = '0;
                ph_d  = '0;
                if (start || pending_q) begin
                    state_d    = S_START;
                    busy_d     = 1'b1;
                    pending_d  = 1'b0;
                    word_idx_d = '0;
                    retry_d    = '0;
                    nack_d     = 1'b0;
                    ack_err_d  = 1'b0;
                end
            end
            S_START: begin
                if (end_c) begin
                    state_d = S_BIT;
                    bit_d   = '0;
                    sh_d    = frame_c;
                end
            end
            S_BIT: begin
                if (tick_c && (ph_q == 2'd2) && ack_bit_c && ACK_EN && sda_i) begin
                    nack_d = 1'b1;
                end
                if (end_c) begin
                    sh_d = {sh_q[FRM_W-2:0], 1'b1};
                    if (bit_q == 5'd26) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (end_c) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // End of frame: retry, advance, or finish the sequence.
                if (end_c) begin
                    nack_d = 1'b0;
                    if (nack_q && (retry_q < RTY_W'(MAX_RETRY))) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_START;
                    end else if (nack_q || last_word_c) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        busy_d     = pending_d;
                        word_idx_d = '0;
                        retry_d    = '0;
                        if (nack_q) begin
                            ack_err_d = 1'b1;
                        end
                    end else begin
                        retry_d    = '0;
                        word_idx_d = word_idx_q + 8'd1;
                        state_d    = S_START;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        // Line drive is a function of the upcoming state/phase so the outputs track it exactly.
        unique case (state_d)
            S_START: begin
                scl_d = ph_d[1];
                sda_d = (ph_d != 2'd0);
            end
            S_BIT: begin
                scl_d = (ph_d == 2'd0) || (ph_d == 2'd3);
                sda_d = ~sh_d[FRM_W-1];
            end
            S_STOP: begin
                scl_d = (ph_d == 2'd0);
                sda_d = (ph_d < 2'd2);
            end
            default: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
        endcase
    end

    assign word_idx = word_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ack_err  = ack_err_q;
    assign scl_oe   = scl_q;
    assign sda_oe   = sda_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer: an I2C slave/decoder monitor checks frames and done events
// against a sequence-level reference model; works with or without I2C_SEQ_ACK_CHECK_EN.
module tb_i2c_reg_sequencer;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned NUM_WORDS  = 8;
    localparam int unsigned INIT_DELAY = 100;
    localparam int unsigned MAX_RETRY  = 3;
    localparam int unsigned RUN_CYC    = NUM_WORDS * 120 * CLK_DIV;
    localparam logic [7:0]  ADDR_W     = 8'h34;

`ifdef I2C_SEQ_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    typedef struct {
        bit          err;
        bit          chk_busy;
        int unsigned cyc;
    } done_exp_t;

    logic        inclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  word_idx;
    logic [15:0] word_data;
    logic        busy, done, ack_err, scl_oe, sda_oe, sda_i;
    logic        ack_pull = 1'b0;
    logic [15:0] tbl [NUM_WORDS];

    logic [23:0] exp_q [$];
    done_exp_t   done_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          dones_seen = 0;
    int          frames_seen = 0;
    int          mode = 0;
    int          att_total = 0;
    int          att_base = 0;
    time         t0 = 0;

    i2c_reg_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .NUM_WORDS (NUM_WORDS),
        .DEV_ADDR  (7'h1A),
        .INIT_DELAY(INIT_DELAY),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .inclk    (inclk),
        .rst_n    (rst_n),
        .start    (start),
        .word_idx (word_idx),
        .word_data(word_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_i    (sda_i)
    );

    assign word_data = tbl[word_idx[2:0]];
    assign sda_i     = ~sda_oe & ~ack_pull;

    always #5 inclk = ~inclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Slave answer policy per frame attempt (attempts counted from att_base).
    function automatic bit nack_for(input int m, input int a);
        if (m == 1) return (a == 3) || (a == 4);
        if (m == 2) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: the frames one sequence should put on the bus, and its done outcome.
    task automatic expect_run(input int m, input int unsigned cyc, input bit chk_busy);
        int a = 0;
        int w = 0;
        int r = 0;
        done_exp_t e;
        e.err = 1'b0;
        forever begin
            exp_q.push_back({ADDR_W, tbl[w]});
            if (ACK_EN && nack_for(m, a)) begin
                a++;
                if (r < int'(MAX_RETRY)) begin
                    r++;
                    continue;
                end
                e.err = 1'b1;
                break;
            end
            a++;
            r = 0;
            if (w == int'(NUM_WORDS) - 1) break;
            w++;
        end
        e.chk_busy = chk_busy;
        e.cyc      = cyc;
        done_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge inclk);
        start = 1'b1;
        @(negedge inclk);
        start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int k = 0;
        while (dones_seen < target && k < budget) begin
            @(negedge inclk);
            k++;
        end
        chk("done_count", 32'(dones_seen), 32'(target));
    endtask

    task automatic rand_table();
        for (int i = 0; i < int'(NUM_WORDS); i++) tbl[i] = 16'($urandom);
    endtask

    // Monitor: I2C slave + frame decoder + done checker.
    initial begin
        logic pscl = 1'b1;
        logic psda = 1'b1;
        logic scl, sda;
        logic [7:0]  sh = '0;
        logic [23:0] fr = '0;
        int   bc = 0;
        int   nb = 0;
        bit   in_frame = 1'b0;
        bit   cur_nack = 1'b0;
        done_exp_t e;
        forever begin
            @(negedge inclk);
            scl = ~scl_oe;
            sda = ~sda_oe & ~ack_pull;
            if (!rst_n) begin
                bc = 0; nb = 0; fr = '0; in_frame = 1'b0; ack_pull = 1'b0;
            end else begin
                if (pscl && scl && psda && !sda) begin
                    bc = 0; nb = 0; fr = '0; in_frame = 1'b1;
                    cur_nack = nack_for(mode, att_total - att_base);
                    att_total++;
                end else if (pscl && scl && !psda && sda) begin
                    if (in_frame) begin
                        frames_seen++;
                        if (exp_q.size() == 0) chk("frame_unexpected", 32'(fr), 32'hFFFF_FFFF);
                        else chk("frame", 32'(fr), 32'(exp_q.pop_front()));
                    end
                    in_frame = 1'b0;
                end else if (!pscl && scl && in_frame) begin
                    if (bc < 8) sh = {sh[6:0], sda};
                    bc++;
                    if (bc == 9) begin
                        fr = {fr[15:0], sh};
                        nb++;
                    end
                end else if (pscl && !scl && in_frame) begin
                    if (bc == 8) begin
                        ack_pull = !(nb == 0 && cur_nack);
                    end else if (bc == 9) begin
                        ack_pull = 1'b0;
                        bc = 0;
                    end
                end
                if (done) begin
                    dones_seen++;
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 32'd0);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_ack_err", 32'(ack_err), 32'(e.err));
                        chk("done_word_idx", 32'(word_idx), 32'd0);
                        if (e.chk_busy) chk("done_busy", 32'(busy), 32'd0);
                        if (e.cyc != 0) chk("done_cycle", 32'((($time - t0) / 10)), e.cyc);
                    end
                end
            end
            pscl = scl;
            psda = sda;
        end
    end

    // Stimulus
    initial begin
        int d0, f0, k;
        for (int i = 0; i < int'(NUM_WORDS); i++) tbl[i] = 16'h1E00 + 16'(i);

        // Reset values
        repeat (3) @(negedge inclk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_word_idx", 32'(word_idx), 32'd0);

        // Automatic first run; a start during INIT must be absorbed
        mode = 0;
        expect_run(0, INIT_DELAY + RUN_CYC, 1'b1);
        @(negedge inclk);
        rst_n = 1'b1;
        t0 = $time;
        repeat (20) @(negedge inclk);
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_scl_oe", 32'(scl_oe), 32'd0);
        pulse_start();
        wait_dones(1, int'(INIT_DELAY + RUN_CYC) + 100);
        repeat (300) @(negedge inclk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("run1_drained", 32'(exp_q.size()), 32'd0);

        // Word 3 address NACKed twice, then ACKed
        repeat ($urandom_range(1, 20)) @(negedge inclk);
        mode = 1;
        att_base = att_total;
        rand_table();
        expect_run(1, 0, 1'b1);
        d0 = dones_seen;
        pulse_start();
        wait_dones(d0 + 1, 2 * int'(RUN_CYC));
        repeat (5) @(negedge inclk);
        chk("retry_ack_err", 32'(ack_err), 32'd0);
        chk("retry_drained", 32'(exp_q.size()), 32'd0);

        // Slave never ACKs; then a clean run clears ack_err
        mode = 2;
        att_base = att_total;
        rand_table();
        expect_run(2, 0, 1'b1);
        d0 = dones_seen;
        pulse_start();
        wait_dones(d0 + 1, 2 * int'(RUN_CYC));
        repeat (5) @(negedge inclk);
        chk("abort_ack_err_sticky", 32'(ack_err), 32'(ACK_EN));
        mode = 0;
        rand_table();
        expect_run(0, 0, 1'b1);
        pulse_start();
        repeat (3) @(negedge inclk);
        chk("ack_err_cleared", 32'(ack_err), 32'd0);
        wait_dones(d0 + 2, 2 * int'(RUN_CYC));

        // Three starts while busy collapse into one re-run
        repeat ($urandom_range(1, 20)) @(negedge inclk);
        rand_table();
        expect_run(0, 0, 1'b0);
        expect_run(0, 0, 1'b1);
        d0 = dones_seen;
        f0 = frames_seen;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(20, 500)) @(negedge inclk);
            pulse_start();
        end
        wait_dones(d0 + 2, 3 * int'(RUN_CYC));
        repeat (300) @(negedge inclk);
        chk("rerun_busy", 32'(busy), 32'd0);
        chk("rerun_frames", 32'(frames_seen - f0), 32'(2 * NUM_WORDS));

        // Reset in the middle of word 5's data byte
        rand_table();
        expect_run(0, 0, 1'b1);
        f0 = frames_seen;
        pulse_start();
        k = 0;
        while (word_idx != 8'd5 && k < int'(RUN_CYC)) begin
            @(negedge inclk);
            k++;
        end
        chk("reach_word5", 32'(word_idx), 32'd5);
        repeat (100) @(negedge inclk);
        chk("frames_before_reset", 32'(frames_seen - f0), 32'd5);
        @(posedge inclk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_scl_oe", 32'(scl_oe), 32'd0);
        chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge inclk);
        expect_run(0, INIT_DELAY + RUN_CYC, 1'b1);
        d0 = dones_seen;
        rst_n = 1'b1;
        t0 = $time;
        repeat (50) @(negedge inclk);
        chk("reinit_word_idx", 32'(word_idx), 32'd0);
        chk("reinit_busy", 32'(busy), 32'd1);
        wait_dones(d0 + 1, int'(INIT_DELAY + RUN_CYC) + 100);

        repeat (20) @(negedge inclk);
        chk("final_frames_drained", 32'(exp_q.size()), 32'd0);
        chk("final_dones_drained", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
